ifetch: RTL and testbench

//  Instruction fetch stage directly upstream of decode. Generates the PC and

---
 rtl/ifetch.sv | 137 +++++++++++++
 tb/tb_ifetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: PC generation, single-outstanding instruction bus
// requests, a one-entry stall buffer and a registered instruction output.
// Jumps flush everything in flight; NOP bubbles fill cycles with no instruction.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {StRst, StReq, StWait, StFull} state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        discard;
    logic        buf_valid;
    logic [31:0] buf_inst;
    logic [31:0] buf_addr;

    logic        rsp_in_wait;
    logic        rsp_accept;

    // Responses only count while a request is outstanding.
    assign rsp_in_wait = (state == StWait) && ibus_rvalid_i;
    // A response goes straight to the output register only if nothing outranks it.
    assign rsp_accept  = rsp_in_wait && !discard && !jump_en_i && !hold_i;

    // Request and address come straight from state registers.
    assign ibus_req_o  = (state == StReq);
    assign ibus_addr_o = pc;

    // Fetch control FSM: PC, outstanding-request tracking and the stall buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StRst;
            pc        <= RESET_PC;
            pend_pc   <= RESET_PC;
            discard   <= 1'b0;
            buf_valid <= 1'b0;
            buf_inst  <= NOP_INST;
            buf_addr  <= RESET_PC;
        end else begin
            unique case (state)
                StRst: begin
                    if (jump_en_i) begin
                        pc <= jump_addr_i;
                    end
                    state <= StReq;
                end
                StReq: begin
                    if (ibus_gnt_i) begin
                        // A granted request is always tracked, even if a jump
                        // arrives with it; its word is then thrown away.
                        pend_pc <= pc;
                        discard <= jump_en_i;
                        pc      <= jump_en_i ? jump_addr_i : pc + 32'd4;
                        state   <= StWait;
                    end else if (jump_en_i) begin
                        pc <= jump_addr_i;
                    end
                end
                StWait: begin
                    if (ibus_rvalid_i) begin
                        discard <= 1'b0;
                        if (jump_en_i) begin
                            pc <= jump_addr_i;
                        end
                        if (!discard && !jump_en_i && hold_i) begin
                            buf_inst  <= ibus_rdata_i;
                            buf_addr  <= pend_pc;
                            buf_valid <= 1'b1;
                            state     <= StFull;
                        end else begin
                            state <= StReq;
                        end
                    end else if (jump_en_i) begin
                        discard <= 1'b1;
                        pc      <= jump_addr_i;
                    end
                end
                StFull: begin
                    if (jump_en_i) begin
                        buf_valid <= 1'b0;
                        pc        <= jump_addr_i;
                        state     <= StReq;
                    end else if (!hold_i) begin
                        // Buffer drains into the output register this cycle.
                        buf_valid <= 1'b0;
                        state     <= StReq;
                    end
                end
                default: begin
                    state <= StRst;
                end
            endcase
        end
    end

    // Output register toward decode: jump > hold > buffer > response > bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o       <= NOP_INST;
            inst_addr_o  <= RESET_PC;
            inst_valid_o <= 1'b0;
        end else if (jump_en_i) begin
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
        end else if (hold_i) begin
            // Decode is stalled: keep presenting the same instruction.
        end else if (buf_valid) begin
            inst_o       <= buf_inst;
            inst_addr_o  <= buf_addr;
            inst_valid_o <= 1'b1;
        end else if (rsp_accept) begin
            inst_o       <= ibus_rdata_i;
            inst_addr_o  <= pend_pc;
            inst_valid_o <= 1'b1;
        end else begin
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed vector table, hand-written reset
// sequence, and randomized bus/hold/jump traffic against a stream-level model.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Model / bus-slave state.
    logic [31:0] exp_next;
    int          n_valid;
    logic        outst;
    int          cd;
    logic [31:0] s_addr;

    ifetch #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .hold_i       (hold),
        .ibus_req_o   (ibus_req),
        .ibus_addr_o  (ibus_addr),
        .ibus_gnt_i   (gnt),
        .ibus_rvalid_i(rvalid),
        .ibus_rdata_i (rdata),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_valid_o (inst_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [31:0] jaddr;
        logic        hold;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_iaddr;
        logic        e_val;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic j, input logic [31:0] ja,
                               input logic h, input logic g, input logic rv,
                               input logic [31:0] rd, input logic ereq,
                               input logic [31:0] eaddr, input logic [31:0] einst,
                               input logic [31:0] eiaddr, input logic evalid);
        vec_t x;
        x.rst = r; x.jmp = j; x.jaddr = ja; x.hold = h; x.gnt = g; x.rv = rv;
        x.rdata = rd; x.e_req = ereq; x.e_addr = eaddr; x.e_inst = einst;
        x.e_iaddr = eiaddr; x.e_val = evalid;
        return x;
    endfunction

    // Instruction memory contents as seen by the bus slave.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[17:2], 16'h0013} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; jump_en = 1'b0; jump_addr = '0; hold = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (n) tick();
        chk("rst_inst", inst, NOP);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_iaddr", inst_addr, RESET_PC);
        chk("rst_req", 32'(ibus_req), 32'd0);
        rst = 1'b0;
        outst = 1'b0;
        cd = 0;
        exp_next = RESET_PC;
        n_valid = 0;
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            rst = tbl[i].rst; jump_en = tbl[i].jmp; jump_addr = tbl[i].jaddr;
            hold = tbl[i].hold; gnt = tbl[i].gnt; rvalid = tbl[i].rv;
            rdata = tbl[i].rdata;
            chk($sformatf("tbl%0d_req", i), 32'(ibus_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), ibus_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_inst", i), inst, tbl[i].e_inst);
            chk($sformatf("tbl%0d_iaddr", i), inst_addr, tbl[i].e_iaddr);
            chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_val));
            tick();
        end
        rst = 1'b0; jump_en = 1'b0; hold = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    endtask

    // Randomized traffic. The model tracks only the expected instruction stream:
    // valid outputs follow the PC sequence (+4, redirected by the latest jump)
    // and carry that address's memory word; jump/hold effects are checked per cycle.
    task automatic run_random(input int ncyc, input int gnt_pct, input int max_lat,
                              input int hold_pct, input int jump_pct, input int spur_pct);
        logic [31:0] o_inst, o_iaddr;
        logic        o_valid;
        for (int c = 0; c < ncyc; c++) begin
            o_inst = inst; o_iaddr = inst_addr; o_valid = inst_valid;
            rvalid = 1'b0; rdata = '0; gnt = 1'b0;
            if (outst) begin
                chk("one_outstanding", 32'(ibus_req), 32'd0);
                if (cd <= 1) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(s_addr);
                    outst  = 1'b0;
                end else begin
                    cd--;
                end
            end else if ($urandom_range(0, 99) < spur_pct) begin
                rvalid = 1'b1;
                rdata  = {16'hBAD0, 16'(c)};
            end
            if (ibus_req && $urandom_range(0, 99) < gnt_pct) begin
                gnt    = 1'b1;
                outst  = 1'b1;
                s_addr = ibus_addr;
                cd     = int'($urandom_range(1, max_lat));
            end
            hold    = ($urandom_range(0, 99) < hold_pct);
            jump_en = ($urandom_range(0, 99) < jump_pct);
            if ($urandom_range(0, 7) == 0) jump_addr = 32'hFFFF_FFF8;
            else jump_addr = 32'($urandom_range(0, 1023)) << 2;
            tick();
            if (jump_en) begin
                chk("jump_inst", inst, NOP);
                chk("jump_valid", 32'(inst_valid), 32'd0);
                chk("jump_iaddr", inst_addr, o_iaddr);
                exp_next = jump_addr;
            end else if (hold) begin
                chk("hold_inst", inst, o_inst);
                chk("hold_iaddr", inst_addr, o_iaddr);
                chk("hold_valid", 32'(inst_valid), 32'(o_valid));
            end else if (inst_valid) begin
                chk("stream_addr", inst_addr, exp_next);
                chk("stream_data", inst, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                n_valid++;
            end else begin
                chk("bubble_inst", inst, NOP);
                chk("bubble_iaddr", inst_addr, o_iaddr);
            end
        end
        jump_en = 1'b0; hold = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; jump_en = 1'b0; jump_addr = '0; hold = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        outst = 1'b0; cd = 0; exp_next = RESET_PC; n_valid = 0;

        //      rst j  jaddr          h  g  rv rdata           req addr           inst           iaddr          val
        tbl.push_back(v(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        NOP,           32'h0,        0));
        tbl.push_back(v(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        NOP,           32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        NOP,           32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0,        NOP,           32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h00500093, 0, 32'h4,        NOP,           32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h4,        32'h00500093,  32'h0,        1));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h00000013, 0, 32'h8,        NOP,           32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h8,        32'h00000013,  32'h4,        1));
        tbl.push_back(v(0, 0, 32'h0,        1, 0, 1, 32'hAAAA0013, 0, 32'hC,        NOP,           32'h4,        0));
        tbl.push_back(v(0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'hC,        NOP,           32'h4,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'hC,        NOP,           32'h4,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'hC,        32'hAAAA0013,  32'h8,        1));
        tbl.push_back(v(0, 1, 32'h100,      0, 0, 0, 32'h0,        0, 32'h10,       NOP,           32'h8,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0, 32'h100,      NOP,           32'h8,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h100,      NOP,           32'h8,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h11110013, 0, 32'h104,      NOP,           32'h8,        0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h104,      32'h11110013,  32'h100,      1));
        tbl.push_back(v(0, 1, 32'h200,      0, 1, 0, 32'h0,        1, 32'h104,      NOP,           32'h100,      0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'hBAD00013, 0, 32'h200,      NOP,           32'h100,      0));
        tbl.push_back(v(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h200,      NOP,           32'h100,      0));
        tbl.push_back(v(0, 0, 32'h0,        1, 0, 1, 32'h22220013, 0, 32'h204,      NOP,           32'h100,      0));
        tbl.push_back(v(0, 1, 32'h300,      1, 0, 0, 32'h0,        0, 32'h204,      NOP,           32'h100,      0));
        tbl.push_back(v(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h300,      NOP,           32'h100,      0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h33330013, 0, 32'h304,      NOP,           32'h100,      0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'hEEEE0013, 1, 32'h304,      32'h33330013,  32'h300,      1));
        tbl.push_back(v(0, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h0,        1, 32'h304,      NOP,           32'h300,      0));
        tbl.push_back(v(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'hFFFFFFFC, NOP,           32'h300,      0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h44440013, 0, 32'h0,        NOP,           32'h300,      0));
        tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        32'h44440013,  32'hFFFFFFFC, 1));

        // Directed table: first fetch, stall buffer, jump in WAIT/REQ/FULL, wrap.
        tick();
        run_table();

        // Straight-line fetch, zero wait: eight words in order, bubbles between.
        do_reset(3);
        run_random(17, 100, 1, 0, 0, 0);
        chk("straight_count", 32'(n_valid), 32'd8);
        chk("straight_last", inst_addr, 32'h1C);

        // Reset while a request is outstanding; the late response must be ignored.
        do_reset(3);
        tick();                                    // RST -> REQ
        chk("r6_req0", 32'(ibus_req), 32'd1);
        gnt = 1'b1; tick(); gnt = 1'b0;            // granted addr 0
        rvalid = 1'b1; rdata = mem_word(32'h0); tick(); rvalid = 1'b0;
        chk("r6_first_valid", 32'(inst_valid), 32'd1);
        chk("r6_req1_addr", ibus_addr, 32'h4);
        hold = 1'b1; gnt = 1'b1; tick(); gnt = 1'b0; // granted addr 4, output held
        chk("r6_wait_req", 32'(ibus_req), 32'd0);
        chk("r6_wait_valid", 32'(inst_valid), 32'd1);
        hold = 1'b0; rst = 1'b1; tick();
        chk("r6_rst_inst", inst, NOP);
        chk("r6_rst_valid", 32'(inst_valid), 32'd0);
        chk("r6_rst_iaddr", inst_addr, RESET_PC);
        chk("r6_rst_req", 32'(ibus_req), 32'd0);
        rst = 1'b0; rvalid = 1'b1; rdata = 32'hBADBAD13; tick(); rvalid = 1'b0;
        chk("r6_late_req", 32'(ibus_req), 32'd1);
        chk("r6_late_addr", ibus_addr, RESET_PC);
        chk("r6_late_valid", 32'(inst_valid), 32'd0);
        chk("r6_late_inst", inst, NOP);
        gnt = 1'b1; tick(); gnt = 1'b0;
        rvalid = 1'b1; rdata = mem_word(RESET_PC); tick(); rvalid = 1'b0;
        chk("r6_refetch_inst", inst, mem_word(RESET_PC));
        chk("r6_refetch_iaddr", inst_addr, RESET_PC);
        chk("r6_refetch_valid", 32'(inst_valid), 32'd1);

        // Randomized traffic: variable grant/latency, holds, jumps, stray rvalids.
        do_reset(3);
        run_random(4000, 70, 4, 25, 6, 10);
        chk("random_progress", 32'(n_valid > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
